// File: rtl/tile_draw_scheduler_if.sv
// Bundles the requester/drawer-facing signals of the tile draw scheduler.
// The scheduler takes the slave view; the requesters plus drawer take the master view.
interface tile_draw_scheduler_if;
    logic [3:0]  req;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_c;
    logic [3:0]  req_au;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic        busy;
    logic [1:0]  grant_id;
    logic        go;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  c_out;
    logic        au_out;
    logic        done;

    modport slave (
        input  req, req_x, req_y, req_c, req_au, done,
        output ack, err, busy, grant_id, go, x_out, y_out, c_out, au_out
    );

    modport master (
        output req, req_x, req_y, req_c, req_au, done,
        input  ack, err, busy, grant_id, go, x_out, y_out, c_out, au_out
    );
endinterface

// File: rtl/tile_draw_scheduler.sv
// Round-robin arbiter that hands one of four draw requests at a time to a 4x4
// square drawer, holds its operands, and reports completion or timeout back.
module tile_draw_scheduler #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    tile_draw_scheduler_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] id);
        onehot4 = 4'b0001 << id;
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [2:0]       c_q, c_d;
    logic             au_q, au_d;
    logic             go_q, go_d;
    logic             busy_q, busy_d;
    logic [3:0]       ack_q, ack_d;
    logic [3:0]       err_q, err_d;

    logic             pick_valid_s;
    logic [1:0]       pick_id_s;
    logic [1:0]       idx_s;
    logic [7:0]       x_arr_s [4];
    logic [6:0]       y_arr_s [4];
    logic [2:0]       c_arr_s [4];

    // Unpack the per-requester operand lanes so they can be picked by index.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            x_arr_s[k] = bus.req_x[8*k +: 8];
            y_arr_s[k] = bus.req_y[7*k +: 7];
            c_arr_s[k] = bus.req_c[3*k +: 3];
        end
    end

    // Round-robin search: first asserted request at or after ptr, wrapping mod 4.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_id_s    = 2'd0;
        idx_s        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx_s = ptr_q + 2'(k);
            if (!pick_valid_s && bus.req[idx_s]) begin
                pick_valid_s = 1'b1;
                pick_id_s    = idx_s;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Next-state, operand capture and output pulse decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        au_d    = au_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_ISSUE;
                    grant_d = pick_id_s;
                    ptr_d   = pick_id_s + 2'd1;
                    cnt_d   = {CNT_W{1'b0}};
                    x_d     = x_arr_s[pick_id_s];
                    y_d     = y_arr_s[pick_id_s];
                    c_d     = c_arr_s[pick_id_s];
                    au_d    = bus.req_au[pick_id_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = {CNT_W{1'b0}};
            end
            ST_WAIT: begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                // A done arriving on the last timeout cycle still counts as success.
                if (bus.done) begin
                    state_d = ST_ACK;
                end else if (cnt_d >= CNT_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        go_d   = (state_d == ST_ISSUE);
        busy_d = (state_d != ST_IDLE);
        ack_d  = (state_d == ST_ACK)   ? onehot4(grant_d) : 4'b0000;
        err_d  = (state_d == ST_ABORT) ? onehot4(grant_d) : 4'b0000;
    end

    // State, operand and output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 2'd0;
            cnt_q   <= {CNT_W{1'b0}};
            x_q     <= 8'd0;
            y_q     <= 7'd0;
            c_q     <= 3'd0;
            au_q    <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 4'b0000;
            err_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            au_q    <= au_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_q;
    assign bus.go       = go_q;
    assign bus.x_out    = x_q;
    assign bus.y_out    = y_q;
    assign bus.c_out    = c_q;
    assign bus.au_out   = au_q;

endmodule

// File: tb/tb_tile_draw_scheduler.sv
// Directed bench for tile_draw_scheduler: a cycle table for arbitration plus
// hand sequences for latency, timeout, collision and mid-operation reset.
module tb_tile_draw_scheduler;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    tile_draw_scheduler_if bus ();

    tile_draw_scheduler #(.TIMEOUT_CYC(64)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       go;
        logic       busy;
        logic [3:0] ack;
        logic [1:0] grant;
        logic [7:0] x;
    } vec_t;

    vec_t vecs[$];

    task automatic av(input logic [3:0] r, input logic d, input logic g, input logic b,
                      input logic [3:0] a, input logic [1:0] gr, input logic [7:0] x);
        vec_t v;
        v.req = r; v.done = d; v.go = g; v.busy = b; v.ack = a; v.grant = gr; v.x = x;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req    = 4'b0000;
        bus.req_x  = 32'd0;
        bus.req_y  = 28'd0;
        bus.req_c  = 12'd0;
        bus.req_au = 4'b0000;
        bus.done   = 1'b0;

        // Cycle table: {req, done} applied, then state after the edge.
        //  req     done go   busy ack      gr    x
        av(4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 8'd0);
        av(4'hF, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 8'd10);
        av(4'hF, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 8'd10);
        av(4'hF, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 8'd10);
        av(4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 8'd10);
        av(4'hF, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd1, 8'd20);
        av(4'hF, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd1, 8'd20);
        av(4'hF, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 8'd20);
        av(4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 8'd20);
        av(4'hF, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd2, 8'd30);
        av(4'hF, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2, 8'd30);
        av(4'hF, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 8'd30);
        av(4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 8'd30);
        av(4'hF, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd3, 8'd40);
        av(4'hF, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd3, 8'd40);
        av(4'hF, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 8'd40);
        av(4'hF, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 8'd40);
        av(4'hF, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 8'd10);
        av(4'hF, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 8'd10);
        av(4'hF, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 8'd10);
        av(4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 8'd10);
        av(4'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 8'd10);
        av(4'hA, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd1, 8'd20);
        av(4'hA, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1, 8'd20);
        av(4'hA, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 8'd20);
        av(4'hA, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 8'd20);
        av(4'hA, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd3, 8'd40);
        av(4'hA, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd3, 8'd40);
        av(4'hA, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 8'd40);
        av(4'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 8'd40);

        // Reset state.
        step();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_go", 32'(bus.go), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_grant", 32'(bus.grant_id), 32'd0);
        chk("rst_ops", {13'd0, bus.x_out, bus.y_out, bus.c_out, bus.au_out}, 32'd0);
        rst = 1'b0;

        // Table-driven arbitration and handshake.
        bus.req_x = {8'd40, 8'd30, 8'd20, 8'd10};
        for (int i = 0; i < vecs.size(); i++) begin
            bus.req  = vecs[i].req;
            bus.done = vecs[i].done;
            step();
            chk($sformatf("v%0d_go", i),    32'(bus.go),       32'(vecs[i].go));
            chk($sformatf("v%0d_busy", i),  32'(bus.busy),     32'(vecs[i].busy));
            chk($sformatf("v%0d_ack", i),   32'(bus.ack),      32'(vecs[i].ack));
            chk($sformatf("v%0d_err", i),   32'(bus.err),      32'd0);
            chk($sformatf("v%0d_grant", i), 32'(bus.grant_id), 32'(vecs[i].grant));
            chk($sformatf("v%0d_x", i),     32'(bus.x_out),    32'(vecs[i].x));
        end
        bus.done = 1'b0;

        // Single request with done 18 cycles after go; operands held against req_x changes.
        bus.req_x  = {8'd0, 8'd20, 8'd0, 8'd0};
        bus.req_y  = {7'd0, 7'd30, 7'd0, 7'd0};
        bus.req_c  = {3'd0, 3'b101, 3'd0, 3'd0};
        bus.req_au = 4'b0100;
        bus.req    = 4'b0100;
        step();
        chk("s1_go", 32'(bus.go), 32'd1);
        chk("s1_grant", 32'(bus.grant_id), 32'd2);
        chk("s1_x", 32'(bus.x_out), 32'd20);
        chk("s1_y", 32'(bus.y_out), 32'd30);
        chk("s1_c", 32'(bus.c_out), 32'd5);
        chk("s1_au", 32'(bus.au_out), 32'd1);
        bus.req   = 4'b0000;
        bus.req_x = {8'd0, 8'd99, 8'd0, 8'd0};
        for (int k = 1; k <= 18; k++) begin
            step();
            chk($sformatf("s1_go_c%0d", k), 32'(bus.go), 32'd0);
            chk($sformatf("s1_xhold_c%0d", k), 32'(bus.x_out), 32'd20);
            chk($sformatf("s1_ack_c%0d", k), 32'(bus.ack), 32'd0);
        end
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("s1_ack", 32'(bus.ack), 32'b0100);
        chk("s1_err", 32'(bus.err), 32'd0);
        step();
        chk("s1_ack_once", 32'(bus.ack), 32'd0);
        chk("s1_idle", 32'(bus.busy), 32'd0);

        // Timeout: ptr is 3, only requester 0 asks; no done ever.
        bus.req = 4'b0001;
        step();
        chk("s2_go", 32'(bus.go), 32'd1);
        chk("s2_grant", 32'(bus.grant_id), 32'd0);
        bus.req = 4'b0000;
        for (int k = 1; k <= 63; k++) begin
            step();
            chk($sformatf("s2_err_c%0d", k), 32'(bus.err), 32'd0);
            chk($sformatf("s2_busy_c%0d", k), 32'(bus.busy), 32'd1);
        end
        step();
        chk("s2_err", 32'(bus.err), 32'b0001);
        chk("s2_noack", 32'(bus.ack), 32'd0);
        step();
        chk("s2_err_once", 32'(bus.err), 32'd0);
        chk("s2_busy_drop", 32'(bus.busy), 32'd0);

        // Collision: done on the final timeout cycle wins.
        bus.req = 4'b0010;
        step();
        chk("s3_grant", 32'(bus.grant_id), 32'd1);
        bus.req = 4'b0000;
        for (int k = 1; k <= 63; k++) begin
            step();
        end
        chk("s3_pre_busy", 32'(bus.busy), 32'd1);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("s3_ack", 32'(bus.ack), 32'b0010);
        chk("s3_err", 32'(bus.err), 32'd0);
        step();
        chk("s3_err_after", 32'(bus.err), 32'd0);

        // Reset during WAIT clears outputs immediately and restarts ptr at 0.
        bus.req_x = {8'd0, 8'd77, 8'd0, 8'd0};
        bus.req   = 4'b0100;
        step();
        bus.req = 4'b0000;
        step();
        chk("s4_wait_busy", 32'(bus.busy), 32'd1);
        chk("s4_wait_x", 32'(bus.x_out), 32'd77);
        rst = 1'b1;
        #1;
        chk("s4_async_busy", 32'(bus.busy), 32'd0);
        chk("s4_async_grant", 32'(bus.grant_id), 32'd0);
        chk("s4_async_ops", {13'd0, bus.x_out, bus.y_out, bus.c_out, bus.au_out}, 32'd0);
        chk("s4_async_pulses", {24'd0, bus.ack, bus.err}, 32'd0);
        bus.done = 1'b1;
        step();
        rst = 1'b0;
        bus.done = 1'b0;
        bus.req = 4'b1001;
        step();
        chk("s4_ptr0_grant", 32'(bus.grant_id), 32'd0);
        chk("s4_go", 32'(bus.go), 32'd1);
        chk("s4_noack", {24'd0, bus.ack, bus.err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
